// File: rtl/cia_pkg.sv
// Shared CIA definitions: register offsets, control-register bit positions
// and the timer input-source encodings.
package cia_pkg;

    localparam logic [1:0] REG_LO   = 2'd0;
    localparam logic [1:0] REG_HI   = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    localparam int CTRL_START   = 0;
    localparam int CTRL_PBON    = 1;
    localparam int CTRL_OUTMODE = 2;
    localparam int CTRL_RUNMODE = 3;
    localparam int CTRL_LOAD    = 4;
    localparam int CTRL_INMODE  = 5;

    typedef enum logic [1:0] {
        INMODE_ECLK   = 2'b00,
        INMODE_CNT    = 2'b01,
        INMODE_TA     = 2'b10,
        INMODE_TA_CNT = 2'b11
    } inmode_e;

endpackage

// File: rtl/cia_tick_sel.sv
// Count-source selector for a CIA interval timer: picks which enable
// advances the counter.
import cia_pkg::*;

module cia_tick_sel (
    input  inmode_e inmode,
    input  logic    eclk_en,
    input  logic    cnt_en,
    input  logic    ta_ufl,
    input  logic    cnt_lvl,
    output logic    src_tick
);

    always_comb begin
        src_tick = 1'b0;
        case (inmode)
            INMODE_ECLK:   src_tick = eclk_en;
            INMODE_CNT:    src_tick = cnt_en;
            INMODE_TA:     src_tick = ta_ufl;
            INMODE_TA_CNT: src_tick = ta_ufl & cnt_lvl;
            default:       src_tick = 1'b0;
        endcase
    end

endmodule

// File: rtl/cia_timer.sv
// 8520-style 16-bit interval timer (CIA timer A or B) with reload latch,
// one-shot/continuous modes and pulse/toggle PB output.
import cia_pkg::*;

module cia_timer #(
    parameter bit          TIMER_B  = 1'b0,
    parameter logic [15:0] LATCH_RV = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eclk_en,
    input  logic       cnt_en,
    input  logic       cnt_lvl,
    input  logic       ta_ufl,
    input  logic       wr,
    input  logic [1:0] sel,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ufl,
    output logic       tmr_out,
    output logic       running
);

    logic [15:0] latch_q, latch_nx;
    logic [15:0] counter_q, counter_nx;
    logic [7:0]  ctrl_q, ctrl_nx;
    logic        ufl_q;
    logic        tog_q, tog_nx;
    logic        src_tick, tick, underflow, force_load, start_rise;
    logic        wr_lo, wr_hi, wr_ctrl;
    inmode_e     inmode;

    // Timer A has only one INMODE bit; its ctrl[6] is stored but never selects cascade.
    assign inmode = TIMER_B ? inmode_e'(ctrl_q[6:5]) : inmode_e'({1'b0, ctrl_q[CTRL_INMODE]});

    cia_tick_sel u_tick_sel (
        .inmode  (inmode),
        .eclk_en (eclk_en),
        .cnt_en  (cnt_en),
        .ta_ufl  (ta_ufl),
        .cnt_lvl (cnt_lvl),
        .src_tick(src_tick)
    );

    assign wr_lo      = wr && (sel == REG_LO);
    assign wr_hi      = wr && (sel == REG_HI);
    assign wr_ctrl    = wr && (sel == REG_CTRL);
    assign tick       = src_tick & ctrl_q[CTRL_START];
    assign underflow  = tick && (counter_q == 16'd0);
    assign force_load = (wr_ctrl & data_in[CTRL_LOAD]) | (wr_hi & ~ctrl_q[CTRL_START]);
    assign start_rise = wr_ctrl & data_in[CTRL_START] & ~ctrl_q[CTRL_START];

    // Next-state: force load beats underflow reload, which beats decrement.
    always_comb begin
        latch_nx   = latch_q;
        counter_nx = counter_q;
        ctrl_nx    = ctrl_q;
        tog_nx     = tog_q;

        if (wr_lo) latch_nx[7:0]  = data_in;
        if (wr_hi) latch_nx[15:8] = data_in;

        if (force_load)     counter_nx = latch_nx;
        else if (underflow) counter_nx = latch_q;
        else if (tick)      counter_nx = counter_q - 16'd1;

        if (underflow && ctrl_q[CTRL_RUNMODE]) ctrl_nx[CTRL_START] = 1'b0;
        if (wr_ctrl) ctrl_nx = {data_in[7:5], 1'b0, data_in[3:0]};
        if (wr_hi && !ctrl_q[CTRL_START] && ctrl_q[CTRL_RUNMODE]) ctrl_nx[CTRL_START] = 1'b1;

        if (start_rise)     tog_nx = 1'b1;
        else if (underflow) tog_nx = ~tog_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q   <= LATCH_RV;
            counter_q <= LATCH_RV;
            ctrl_q    <= 8'h00;
            ufl_q     <= 1'b0;
            tog_q     <= 1'b0;
        end else begin
            latch_q   <= latch_nx;
            counter_q <= counter_nx;
            ctrl_q    <= ctrl_nx;
            ufl_q     <= underflow;
            tog_q     <= tog_nx;
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (sel)
            REG_LO:   data_out = counter_q[7:0];
            REG_HI:   data_out = counter_q[15:8];
            REG_CTRL: data_out = {ctrl_q[7], (TIMER_B ? ctrl_q[6] : 1'b0), ctrl_q[5], 1'b0, ctrl_q[3:0]};
            default:  data_out = 8'h00;
        endcase
    end

    assign ufl     = ufl_q;
    assign tmr_out = ctrl_q[CTRL_OUTMODE] ? tog_q : ufl_q;
    assign running = ctrl_q[CTRL_START];

endmodule

// File: tb/tb_cia_timer.sv
// Directed bench for cia_timer: timer A and timer B instances share stimulus.
module tb_cia_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       eclk_en = 1'b0, cnt_en = 1'b0, cnt_lvl = 1'b0, ta_ufl = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out_a, data_out_b;
    logic       ufl_a, ufl_b, tmr_a, tmr_b, run_a, run_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cia_timer #(.TIMER_B(1'b0)) dut_a (
        .clk(clk), .reset(reset), .eclk_en(eclk_en), .cnt_en(cnt_en), .cnt_lvl(cnt_lvl),
        .ta_ufl(ta_ufl), .wr(wr), .sel(sel), .data_in(data_in), .data_out(data_out_a),
        .ufl(ufl_a), .tmr_out(tmr_a), .running(run_a)
    );

    cia_timer #(.TIMER_B(1'b1)) dut_b (
        .clk(clk), .reset(reset), .eclk_en(eclk_en), .cnt_en(cnt_en), .cnt_lvl(cnt_lvl),
        .ta_ufl(ta_ufl), .wr(wr), .sel(sel), .data_in(data_in), .data_out(data_out_b),
        .ufl(ufl_b), .tmr_out(tmr_b), .running(run_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr = 1'b0; eclk_en = 1'b0; cnt_en = 1'b0; ta_ufl = 1'b0; cnt_lvl = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic write_reg(input logic [1:0] s, input logic [7:0] d, input logic e);
        sel = s; data_in = d; wr = 1'b1; eclk_en = e;
        step();
        wr = 1'b0; eclk_en = 1'b0;
    endtask

    task automatic read_reg(input bit use_b, input logic [1:0] s, output logic [7:0] v);
        sel = s;
        #1;
        v = use_b ? data_out_b : data_out_a;
    endtask

    task automatic read_cnt(input bit use_b, output logic [15:0] v);
        logic [7:0] lo, hi;
        read_reg(use_b, 2'd0, lo);
        read_reg(use_b, 2'd1, hi);
        v = {hi, lo};
    endtask

    task automatic pulse(input logic e, input logic ta);
        eclk_en = e; ta_ufl = ta;
        step();
        eclk_en = 1'b0; ta_ufl = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] cnt;
        logic [7:0]  c;
        do_reset();
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL reset_cnt got %h expected ffff", cnt); end
        read_reg(1'b0, 2'd2, c);
        checks++; if (c !== 8'h00) begin failures++; $display("[TB] FAIL reset_ctrl got %h expected 00", c); end
        checks++; if ({ufl_a, tmr_a, run_a} !== 3'b000) begin failures++; $display("[TB] FAIL reset_outs got %b expected 000", {ufl_a, tmr_a, run_a}); end
        write_reg(2'd3, 8'h5A, 1'b0);
        read_reg(1'b0, 2'd3, c);
        checks++; if (c !== 8'h00) begin failures++; $display("[TB] FAIL unused_reg got %h expected 00", c); end
    endtask

    task automatic test_continuous();
        logic [15:0] cnt, exp_cnt;
        logic        exp_ufl;
        int          n;
        do_reset();
        write_reg(2'd0, 8'h03, 1'b0);
        write_reg(2'd1, 8'h00, 1'b0);
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'd3) begin failures++; $display("[TB] FAIL cont_load got %h expected 0003", cnt); end
        write_reg(2'd2, 8'h01, 1'b0);
        for (int c = 0; c < 80; c++) begin
            eclk_en = (c % 10 == 0);
            step();
            eclk_en = 1'b0;
            exp_ufl = (c == 30 || c == 70);
            checks++; if (ufl_a !== exp_ufl) begin failures++; $display("[TB] FAIL cont_ufl c=%0d got %b expected %b", c, ufl_a, exp_ufl); end
            if (c % 10 == 0) begin
                n = c / 10 + 1;
                exp_cnt = 16'((3 - n) & 3);
                read_cnt(1'b0, cnt);
                checks++; if (cnt !== exp_cnt) begin failures++; $display("[TB] FAIL cont_cnt tick=%0d got %h expected %h", n, cnt, exp_cnt); end
            end
        end
    endtask

    task automatic test_one_shot();
        logic [15:0] cnt;
        logic [7:0]  c;
        do_reset();
        write_reg(2'd2, 8'h08, 1'b0);
        write_reg(2'd0, 8'h02, 1'b0);
        write_reg(2'd1, 8'h00, 1'b0);
        read_reg(1'b0, 2'd2, c);
        checks++; if (c !== 8'h09) begin failures++; $display("[TB] FAIL os_ctrl got %h expected 09", c); end
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'd2) begin failures++; $display("[TB] FAIL os_load got %h expected 0002", cnt); end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        checks++; if (ufl_a !== 1'b0) begin failures++; $display("[TB] FAIL os_early_ufl got %b expected 0", ufl_a); end
        pulse(1'b1, 1'b0);
        checks++; if ({ufl_a, run_a} !== 2'b10) begin failures++; $display("[TB] FAIL os_ufl_run got %b expected 10", {ufl_a, run_a}); end
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'd2) begin failures++; $display("[TB] FAIL os_reload got %h expected 0002", cnt); end
        pulse(1'b1, 1'b0);
        read_cnt(1'b0, cnt);
        checks++; if ({ufl_a, cnt} !== {1'b0, 16'd2}) begin failures++; $display("[TB] FAIL os_stopped got %b/%h expected 0/0002", ufl_a, cnt); end
    endtask

    task automatic test_force_load();
        logic [15:0] cnt;
        logic [7:0]  c;
        do_reset();
        write_reg(2'd0, 8'h05, 1'b0);
        write_reg(2'd1, 8'h00, 1'b0);
        write_reg(2'd2, 8'h01, 1'b0);
        write_reg(2'd0, 8'h00, 1'b0);
        write_reg(2'd1, 8'h01, 1'b0);
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'd5) begin failures++; $display("[TB] FAIL fl_hold got %h expected 0005", cnt); end
        write_reg(2'd2, 8'h11, 1'b1);
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'h0100) begin failures++; $display("[TB] FAIL fl_load got %h expected 0100", cnt); end
        read_reg(1'b0, 2'd2, c);
        checks++; if (c !== 8'h01) begin failures++; $display("[TB] FAIL fl_ctrl got %h expected 01", c); end
        pulse(1'b1, 1'b0);
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'h00FF) begin failures++; $display("[TB] FAIL fl_dec got %h expected 00ff", cnt); end
    endtask

    task automatic test_cascade();
        logic [15:0] cnt;
        logic [7:0]  c;
        do_reset();
        write_reg(2'd0, 8'h01, 1'b0);
        write_reg(2'd1, 8'h00, 1'b0);
        write_reg(2'd2, 8'h41, 1'b0);
        read_reg(1'b1, 2'd2, c);
        checks++; if (c !== 8'h41) begin failures++; $display("[TB] FAIL casc_ctrl_b got %h expected 41", c); end
        read_reg(1'b0, 2'd2, c);
        checks++; if (c !== 8'h01) begin failures++; $display("[TB] FAIL casc_ctrl_a got %h expected 01", c); end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        read_cnt(1'b1, cnt);
        checks++; if ({ufl_b, cnt} !== {1'b0, 16'd1}) begin failures++; $display("[TB] FAIL casc_eclk_ign got %b/%h expected 0/0001", ufl_b, cnt); end
        pulse(1'b0, 1'b1);
        read_cnt(1'b1, cnt);
        checks++; if ({ufl_b, cnt} !== {1'b0, 16'd0}) begin failures++; $display("[TB] FAIL casc_p1 got %b/%h expected 0/0000", ufl_b, cnt); end
        pulse(1'b0, 1'b1);
        read_cnt(1'b1, cnt);
        checks++; if ({ufl_b, cnt} !== {1'b1, 16'd1}) begin failures++; $display("[TB] FAIL casc_p2 got %b/%h expected 1/0001", ufl_b, cnt); end
        pulse(1'b0, 1'b1);
        read_cnt(1'b1, cnt);
        checks++; if ({ufl_b, cnt} !== {1'b0, 16'd0}) begin failures++; $display("[TB] FAIL casc_p3 got %b/%h expected 0/0000", ufl_b, cnt); end
    endtask

    task automatic test_tmr_out();
        do_reset();
        write_reg(2'd0, 8'h00, 1'b0);
        write_reg(2'd1, 8'h00, 1'b0);
        write_reg(2'd2, 8'h05, 1'b0);
        checks++; if ({tmr_a, ufl_a} !== 2'b10) begin failures++; $display("[TB] FAIL tog_start got %b expected 10", {tmr_a, ufl_a}); end
        pulse(1'b1, 1'b0);
        checks++; if ({tmr_a, ufl_a} !== 2'b01) begin failures++; $display("[TB] FAIL tog_1 got %b expected 01", {tmr_a, ufl_a}); end
        step();
        checks++; if ({tmr_a, ufl_a} !== 2'b00) begin failures++; $display("[TB] FAIL tog_hold got %b expected 00", {tmr_a, ufl_a}); end
        pulse(1'b1, 1'b0);
        checks++; if ({tmr_a, ufl_a} !== 2'b11) begin failures++; $display("[TB] FAIL tog_2 got %b expected 11", {tmr_a, ufl_a}); end
        write_reg(2'd2, 8'h01, 1'b0);
        checks++; if ({tmr_a, ufl_a} !== 2'b00) begin failures++; $display("[TB] FAIL pulse_idle got %b expected 00", {tmr_a, ufl_a}); end
        pulse(1'b1, 1'b0);
        checks++; if ({tmr_a, ufl_a} !== 2'b11) begin failures++; $display("[TB] FAIL pulse_hi got %b expected 11", {tmr_a, ufl_a}); end
        step();
        checks++; if ({tmr_a, ufl_a} !== 2'b00) begin failures++; $display("[TB] FAIL pulse_end got %b expected 00", {tmr_a, ufl_a}); end
    endtask

    task automatic test_reset_mid_count();
        logic [15:0] cnt;
        int          ufl_seen;
        do_reset();
        write_reg(2'd0, 8'h34, 1'b0);
        write_reg(2'd1, 8'h12, 1'b0);
        write_reg(2'd2, 8'h05, 1'b0);
        read_cnt(1'b0, cnt);
        checks++; if ({cnt, tmr_a, run_a} !== {16'h1234, 2'b11}) begin failures++; $display("[TB] FAIL mid_pre got %h/%b expected 1234/11", cnt, {tmr_a, run_a}); end
        eclk_en = 1'b1;
        reset = 1'b1;
        #1;
        checks++; if ({ufl_a, tmr_a, run_a} !== 3'b000) begin failures++; $display("[TB] FAIL mid_outs got %b expected 000", {ufl_a, tmr_a, run_a}); end
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL mid_cnt got %h expected ffff", cnt); end
        step();
        reset = 1'b0;
        ufl_seen = 0;
        for (int c = 0; c < 30; c++) begin
            eclk_en = (c % 10 == 0);
            step();
            eclk_en = 1'b0;
            if (ufl_a) ufl_seen++;
        end
        checks++; if (ufl_seen != 0) begin failures++; $display("[TB] FAIL mid_no_ufl got %0d expected 0", ufl_seen); end
        read_cnt(1'b0, cnt);
        checks++; if (cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL mid_idle got %h expected ffff", cnt); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_force_load();
        test_cascade();
        test_tmr_out();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
